subscription_checker: RTL and testbench

Combinational-compare, registered-output plan selector for a mobile subscription checker. It takes five candidate plans (cost, talk allowance and data allowance each) plus a user profile (budget, average talk, average data, and two preference weights). It outputs a one-hot recommendation of the best affordable plan that covers the user's usage, plus a flag saying whether any such plan exists. It is a leaf block, driven by the plan-table and user-profile front end.

---
 rtl/subscription_checker_pkg.sv | 16 +
 rtl/subscription_checker_plan_eval.sv | 27 ++
 rtl/subscription_checker.sv | 84 ++++++++
 tb/tb_subscription_checker.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/subscription_checker_pkg.sv
// Shared widths and the plan record used by the subscription checker and its
// per-plan evaluator.
package subscription_pkg;

  localparam int NUM_PLANS = 5;
  localparam int VAL_W     = 6;
  localparam int WGT_W     = 3;
  localparam int SCORE_W   = 10;

  typedef struct packed {
    logic [VAL_W-1:0] cost;
    logic [VAL_W-1:0] talk;
    logic [VAL_W-1:0] data;
  } plan_t;

endpackage

// File: rtl/subscription_checker_plan_eval.sv
// Combinational evaluator for one plan: affordability/coverage check and the
// weighted preference score.
module plan_eval
  import subscription_pkg::*;
(
  input  plan_t              plan,
  input  logic [VAL_W-1:0]   budjet,
  input  logic [VAL_W-1:0]   avgtalk,
  input  logic [VAL_W-1:0]   avgdata,
  input  logic [WGT_W-1:0]   r1,
  input  logic [WGT_W-1:0]   r2,
  output logic               eligible,
  output logic [SCORE_W-1:0] score
);

  logic [8:0] talk_prod;
  logic [8:0] data_prod;

  // Eligibility and score; products widened so the sum never truncates (max 882).
  always_comb begin
    eligible  = (plan.cost <= budjet) && (plan.talk >= avgtalk) && (plan.data >= avgdata);
    talk_prod = {6'd0, r1} * {3'd0, plan.talk};
    data_prod = {6'd0, r2} * {3'd0, plan.data};
    score     = {1'b0, talk_prod} + {1'b0, data_prod};
  end

endmodule

// File: rtl/subscription_checker.sv
// Registered-output plan selector: picks the highest-scoring eligible plan
// (lowest index on ties) and flags whether any plan qualifies.
module subscription_checker
  import subscription_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] a0, a1, a2, a3, a4,
  input  logic [5:0] b0, b1, b2, b3, b4,
  input  logic [5:0] c0, c1, c2, c3, c4,
  input  logic [2:0] r1,
  input  logic [2:0] r2,
  input  logic [5:0] budjet,
  input  logic [5:0] avgtalk,
  input  logic [5:0] avgdata,
  output logic       s0, s1, s2, s3, s4,
  output logic       s
);

  plan_t                plans    [NUM_PLANS];
  logic [NUM_PLANS-1:0] elig;
  logic [SCORE_W-1:0]   score    [NUM_PLANS];
  logic [SCORE_W-1:0]   best_score;
  logic                 found;
  logic [NUM_PLANS-1:0] sel_d, sel_q;
  logic                 any_d, any_q;

  assign plans[0] = '{cost: a0, talk: b0, data: c0};
  assign plans[1] = '{cost: a1, talk: b1, data: c1};
  assign plans[2] = '{cost: a2, talk: b2, data: c2};
  assign plans[3] = '{cost: a3, talk: b3, data: c3};
  assign plans[4] = '{cost: a4, talk: b4, data: c4};

  for (genvar g = 0; g < NUM_PLANS; g++) begin : g_eval
    plan_eval u_eval (
      .plan     (plans[g]),
      .budjet   (budjet),
      .avgtalk  (avgtalk),
      .avgdata  (avgdata),
      .r1       (r1),
      .r2       (r2),
      .eligible (elig[g]),
      .score    (score[g])
    );
  end

  // Arg-max over eligible plans; strict '>' keeps the lowest index on ties.
  always_comb begin
    found      = 1'b0;
    best_score = {SCORE_W{1'b0}};
    sel_d      = {NUM_PLANS{1'b0}};
    for (int i = 0; i < NUM_PLANS; i++) begin
      if (elig[i] && (!found || (score[i] > best_score))) begin
        found      = 1'b1;
        best_score = score[i];
        sel_d      = 5'b00001 << i;
      end else begin
        found      = found;
        best_score = best_score;
        sel_d      = sel_d;
      end
    end
    any_d = found;
  end

  // Output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= 5'b00000;
      any_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      any_q <= any_d;
    end
  end

  assign s0 = sel_q[0];
  assign s1 = sel_q[1];
  assign s2 = sel_q[2];
  assign s3 = sel_q[3];
  assign s4 = sel_q[4];
  assign s  = any_q;

endmodule

// File: tb/tb_subscription_checker.sv
// Directed, table-driven bench for subscription_checker with hand-computed
// expectations plus reset/latency sequences.
module tb_subscription_checker;

  typedef struct {
    logic [4:0][5:0] a;
    logic [4:0][5:0] b;
    logic [4:0][5:0] c;
    logic [2:0]      r1;
    logic [2:0]      r2;
    logic [5:0]      bud;
    logic [5:0]      at;
    logic [5:0]      ad;
    logic [4:0]      exp_sel;
    logic            exp_s;
    string           name;
  } vec_t;

  localparam int NV = 9;

  logic       clk;
  logic       rst_n;
  logic [5:0] a0, a1, a2, a3, a4;
  logic [5:0] b0, b1, b2, b3, b4;
  logic [5:0] c0, c1, c2, c3, c4;
  logic [2:0] r1, r2;
  logic [5:0] budjet, avgtalk, avgdata;
  logic       s0, s1, s2, s3, s4, s;

  int n_cmp;
  int n_bad;
  vec_t vecs [NV];

  subscription_checker dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .r1(r1), .r2(r2), .budjet(budjet), .avgtalk(avgtalk), .avgdata(avgdata),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s(s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0][5:0] pk5(input logic [5:0] v0, v1, v2, v3, v4);
    return {v4, v3, v2, v1, v0};
  endfunction

  task automatic apply(input vec_t v);
    a0 = v.a[0]; a1 = v.a[1]; a2 = v.a[2]; a3 = v.a[3]; a4 = v.a[4];
    b0 = v.b[0]; b1 = v.b[1]; b2 = v.b[2]; b3 = v.b[3]; b4 = v.b[4];
    c0 = v.c[0]; c1 = v.c[1]; c2 = v.c[2]; c3 = v.c[3]; c4 = v.c[4];
    r1 = v.r1; r2 = v.r2; budjet = v.bud; avgtalk = v.at; avgdata = v.ad;
  endtask

  task automatic check(input string name, input logic [4:0] sel_exp, input logic s_exp);
    logic [4:0] sel_act;
    sel_act = {s4, s3, s2, s1, s0};
    n_cmp++;
    if (sel_act !== sel_exp) begin
      n_bad++;
      $display("FAIL %s sel: got %b expected %b", name, sel_act, sel_exp);
    end
    n_cmp++;
    if (s !== s_exp) begin
      n_bad++;
      $display("FAIL %s s: got %b expected %b", name, s, s_exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{a: pk5(18,18,18,18,18), b: pk5(16,17,18,19,20), c: pk5(20,19,18,17,16),
                r1: 3'd2, r2: 3'd3, bud: 6'd20, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b00001, exp_s: 1'b1, name: "desc_scores"};
    vecs[1] = '{a: pk5(18,18,18,18,18), b: pk5(16,18,20,22,24), c: pk5(20,19,18,17,16),
                r1: 3'd1, r2: 3'd2, bud: 6'd20, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b00001, exp_s: 1'b1, name: "all_tied"};
    vecs[2] = '{a: pk5(21,18,18,18,18), b: pk5(16,17,18,19,20), c: pk5(20,19,18,17,16),
                r1: 3'd2, r2: 3'd3, bud: 6'd20, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b00010, exp_s: 1'b1, name: "best_inelig"};
    vecs[3] = '{a: pk5(18,18,18,18,18), b: pk5(16,17,18,19,20), c: pk5(20,19,18,17,16),
                r1: 3'd2, r2: 3'd3, bud: 6'd10, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b00000, exp_s: 1'b0, name: "none_elig"};
    // Only plan 3 passes, each at exact equality; the others score higher but fail one check.
    vecs[4] = '{a: pk5(21,18,18,20,21), b: pk5(30,15,30,16,30), c: pk5(30,30,15,16,30),
                r1: 3'd2, r2: 3'd3, bud: 6'd20, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b01000, exp_s: 1'b1, name: "boundary_eq"};
    vecs[5] = '{a: pk5(21,18,18,18,18), b: pk5(16,17,18,19,20), c: pk5(20,19,18,17,16),
                r1: 3'd0, r2: 3'd0, bud: 6'd20, at: 6'd16, ad: 6'd16,
                exp_sel: 5'b00010, exp_s: 1'b1, name: "zero_weights"};
    // Scores 70,280,441,441,35: tie between plans 2 and 3.
    vecs[6] = '{a: pk5(0,0,0,0,0), b: pk5(63,63,63,63,63), c: pk5(10,40,63,63,5),
                r1: 3'd0, r2: 3'd7, bud: 6'd0, at: 6'd63, ad: 6'd0,
                exp_sel: 5'b00100, exp_s: 1'b1, name: "tie_mid"};
    // Scores 875 x4 and 882: the winner exceeds 9 bits.
    vecs[7] = '{a: pk5(63,63,63,63,63), b: pk5(63,63,63,63,63), c: pk5(62,62,62,62,63),
                r1: 3'd7, r2: 3'd7, bud: 6'd63, at: 6'd63, ad: 6'd0,
                exp_sel: 5'b10000, exp_s: 1'b1, name: "max_score"};
    vecs[8] = '{a: pk5(5,5,5,5,5), b: pk5(10,20,30,40,50), c: pk5(9,9,9,9,9),
                r1: 3'd3, r2: 3'd0, bud: 6'd5, at: 6'd10, ad: 6'd9,
                exp_sel: 5'b10000, exp_s: 1'b1, name: "ascending"};

    // Reset held with live inputs: outputs must stay cleared.
    rst_n = 1'b0;
    apply(vecs[0]);
    step();
    check("reset_hold", 5'b00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("reset_release", 5'b00001, 1'b1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i]);
      step();
      check(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_s);
    end

    // Back-to-back: each result tracks the inputs of the immediately preceding edge.
    @(negedge clk);
    apply(vecs[3]);
    step();
    check("b2b_none", 5'b00000, 1'b0);
    @(negedge clk);
    apply(vecs[4]);
    step();
    check("b2b_boundary", 5'b01000, 1'b1);

    // Mid-stream reset and recovery.
    @(negedge clk);
    apply(vecs[0]);
    step();
    check("pre_reset", 5'b00001, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    step();
    check("mid_reset", 5'b00000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset", 5'b00001, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
